fdtd_sweep_ctrl: RTL and testbench

FDTD_SWEEP_CTRL -- requirements
Module: fdtd_sweep_ctrl

---
 rtl/fdtd_sweep_ctrl.sv | 133 +++++++++++++
 tb/tb_fdtd_sweep_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fdtd_sweep_ctrl.sv
// FDTD sweep sequencer: for each time step, reads every cell for the H update and then for the E update.
// Write-back strobes follow each read by PIPE_LATENCY cycles. Each phase drains before the next phase starts.
module fdtd_sweep_ctrl #(
    parameter int ADDR_WIDTH   = 10,
    parameter int STEP_WIDTH   = 16,
    parameter int PIPE_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] cell_count_i,
    input  logic [STEP_WIDTH-1:0] step_count_i,
    input  logic                  rd_stall_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic                  phase_o,
    output logic [STEP_WIDTH-1:0] step_idx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_H_RD, S_H_DRAIN, S_E_RD, S_E_DRAIN, S_DONE
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cell_q;
    logic [ADDR_WIDTH-1:0]   cell_cnt_q;
    logic [STEP_WIDTH-1:0]   step_cnt_q;
    logic [STEP_WIDTH-1:0]   step_idx_q;
    logic                    phase_q;
    logic [PIPE_LATENCY-1:0] vld_q;
    logic [ADDR_WIDTH-1:0]   addr_q [PIPE_LATENCY];

    logic in_rd;
    logic last_cell;
    logic last_step;

    assign in_rd     = (state_q == S_H_RD) || (state_q == S_E_RD);
    // Comparing against count-1 avoids needing a counter that can reach 2^ADDR_WIDTH.
    assign last_cell = (cell_q == cell_cnt_q - ADDR_WIDTH'(1));
    assign last_step = (step_idx_q == step_cnt_q - STEP_WIDTH'(1));

    assign rd_en_o    = in_rd && !rd_stall_i;
    assign rd_addr_o  = cell_q;
    assign wr_en_o    = vld_q[PIPE_LATENCY-1];
    assign wr_addr_o  = vld_q[PIPE_LATENCY-1] ? addr_q[PIPE_LATENCY-1] : '0;
    assign phase_o    = phase_q;
    assign step_idx_o = step_idx_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cell_q     <= '0;
            cell_cnt_q <= '0;
            step_cnt_q <= '0;
            step_idx_q <= '0;
            phase_q    <= 1'b0;
            vld_q      <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= rd_en_o;
            addr_q[0] <= rd_addr_o;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end

            if (abort_i && state_q != S_IDLE) begin
                // Dropping the valids cancels every write still in flight.
                state_q    <= S_IDLE;
                vld_q      <= '0;
                cell_q     <= '0;
                step_idx_q <= '0;
                phase_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            if (cell_count_i == '0 || step_count_i == '0) begin
                                state_q <= S_DONE;
                            end else begin
                                cell_cnt_q <= cell_count_i;
                                step_cnt_q <= step_count_i;
                                cell_q     <= '0;
                                step_idx_q <= '0;
                                phase_q    <= 1'b0;
                                state_q    <= S_H_RD;
                            end
                        end
                    end
                    S_H_RD, S_E_RD: begin
                        if (rd_en_o) begin
                            if (last_cell) begin
                                cell_q  <= '0;
                                state_q <= (state_q == S_H_RD) ? S_H_DRAIN : S_E_DRAIN;
                            end else begin
                                cell_q <= cell_q + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    S_H_DRAIN: begin
                        if (vld_q == '0) begin
                            phase_q <= 1'b1;
                            state_q <= S_E_RD;
                        end
                    end
                    S_E_DRAIN: begin
                        if (vld_q == '0) begin
                            phase_q <= 1'b0;
                            if (last_step) begin
                                state_q <= S_DONE;
                            end else begin
                                step_idx_q <= step_idx_q + STEP_WIDTH'(1);
                                state_q    <= S_H_RD;
                            end
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fdtd_sweep_ctrl.sv
// Bench for fdtd_sweep_ctrl: a table of runs plus a mid-drain reset sequence.
// A negedge monitor checks reads against a model and writes against a scoreboard queue.
module tb_fdtd_sweep_ctrl;

    localparam int AW = 10;
    localparam int SW = 16;
    localparam int L  = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [AW-1:0] cell_count_i = '0;
    logic [SW-1:0] step_count_i = '0;
    logic          rd_stall_i = 1'b0;
    logic          rd_en_o, wr_en_o, phase_o, busy_o, done_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [SW-1:0] step_idx_o;

    fdtd_sweep_ctrl #(.ADDR_WIDTH(AW), .STEP_WIDTH(SW), .PIPE_LATENCY(L)) dut (
        .CLK(CLK), .RST(RST), .start_i(start_i), .abort_i(abort_i),
        .cell_count_i(cell_count_i), .step_count_i(step_count_i), .rd_stall_i(rd_stall_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .phase_o(phase_o), .step_idx_o(step_idx_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic ph;
        int   addr;
        int   step;
        int   due;
    } ent_t;

    typedef struct {
        int          cells;
        int          steps;
        logic [31:0] stall;
        int          restart_k;
        int          abort_k;
        int          exp_rd;
        int          exp_done;
        int          exp_busy;
    } vec_t;

    ent_t exp_rd[$];
    ent_t wr_q[$];
    int   vec = 0;
    int   miss = 0;
    int   cyc = 0;
    int   rd_total = 0;
    int   done_total = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (rd_en_o) begin
                ent_t e;
                rd_total++;
                if (exp_rd.size() == 0) begin
                    check("unexpected_rd", 1, 0);
                end else begin
                    e = exp_rd.pop_front();
                    check("rd_addr", rd_addr_o, e.addr);
                    check("rd_phase", phase_o, e.ph);
                    check("rd_step", step_idx_o, e.step);
                    e.due = cyc + L;
                    wr_q.push_back(e);
                end
            end
            if (wr_en_o) begin
                ent_t w;
                if (wr_q.size() == 0) begin
                    check("unexpected_wr", 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", wr_addr_o, w.addr);
                    check("wr_phase", phase_o, w.ph);
                    check("wr_latency", cyc, w.due);
                end
            end
            if (done_o) done_total++;
        end
    end

    task automatic load_model(input int c, input int s);
        ent_t e;
        exp_rd.delete();
        wr_q.delete();
        if (c > 0 && s > 0) begin
            for (int st = 0; st < s; st++) begin
                for (int ph = 0; ph < 2; ph++) begin
                    for (int a = 0; a < c; a++) begin
                        e.ph = logic'(ph);
                        e.addr = a;
                        e.step = st;
                        e.due = 0;
                        exp_rd.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic run_case(input vec_t v);
        int k;
        rd_total = 0;
        done_total = 0;
        @(posedge CLK); #1;
        load_model(v.cells, v.steps);
        cell_count_i = AW'(v.cells);
        step_count_i = SW'(v.steps);
        rd_stall_i = 1'b0;
        start_i = 1'b1;
        @(posedge CLK); #1;
        start_i = 1'b0;
        k = 0;
        while (busy_o && k < 5000) begin
            rd_stall_i = (k < 32) ? v.stall[k] : 1'b0;
            start_i = (k == v.restart_k);
            if (k == v.restart_k) begin
                cell_count_i = AW'(7);
                step_count_i = SW'(3);
            end
            abort_i = (k == v.abort_k);
            @(posedge CLK); #1;
            start_i = 1'b0;
            if (abort_i) begin
                abort_i = 1'b0;
                exp_rd.delete();
                wr_q.delete();
            end
            k++;
        end
        if (k >= 5000) begin
            check("run_timeout", 1, 0);
            RST = 1'b1;
            #2 RST = 1'b0;
        end
        rd_stall_i = 1'b0;
        repeat (L + 4) @(posedge CLK);
        #1;
        check("rd_total", rd_total, v.exp_rd);
        check("done_total", done_total, v.exp_done);
        if (v.exp_busy >= 0) check("busy_cycles", k, v.exp_busy);
        check("reads_left", exp_rd.size(), 0);
        check("writes_left", wr_q.size(), 0);
    endtask

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4,    1, 32'h0,        -1, -1, 8,    1, 15};
        tbl[1] = '{3,    2, 32'h2,        -1, -1, 12,   1, 26};
        tbl[2] = '{0,    3, 32'h0,        -1, -1, 0,    1, 1};
        tbl[3] = '{5,    0, 32'h0,        -1, -1, 0,    1, 1};
        tbl[4] = '{3,    1, 32'h0,         3, -1, 6,    1, 13};
        tbl[5] = '{4,    1, 32'h0,        -1,  9, 7,    0, 10};
        tbl[6] = '{2,    3, 32'h0F0F,     -1, -1, 12,   1, -1};
        tbl[7] = '{1023, 1, 32'h0,        -1, -1, 2046, 1, 2053};

        repeat (2) @(posedge CLK);
        #1;
        check("reset_outputs", {rd_en_o, wr_en_o, rd_addr_o, wr_addr_o, phase_o,
                                step_idx_o, busy_o, done_o}, 0);
        RST = 1'b0;

        for (int i = 0; i < 8; i++) run_case(tbl[i]);

        // Asynchronous reset while the H-phase writes are still draining.
        @(posedge CLK); #1;
        load_model(4, 1);
        cell_count_i = AW'(4);
        step_count_i = SW'(1);
        start_i = 1'b1;
        @(posedge CLK); #1;
        start_i = 1'b0;
        repeat (4) @(posedge CLK);
        #3;
        check("pre_rst_busy", busy_o, 1);
        check("pre_rst_drain_wr", {wr_en_o, rd_en_o}, 2'b10);
        RST = 1'b1;
        #1;
        check("rst_async_outputs", {rd_en_o, wr_en_o, rd_addr_o, wr_addr_o, phase_o,
                                    step_idx_o, busy_o, done_o}, 0);
        exp_rd.delete();
        wr_q.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        check("post_rst_idle", {busy_o, wr_en_o}, 0);
        run_case(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
